// File: rtl/dsp_pkg.sv
// ----------------------------------------------------------------------------
// dsp_pkg
// Shared helpers for DSP datapath blocks.
//   DEFAULT_WIDTH : default per-lane data width
//   clog2()       : ceiling log2, usable in constant expressions
//   clamp_delay() : folds a requested delay into the supported range 1..max_delay
// ----------------------------------------------------------------------------
package dsp_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((64'(1) << res) < 64'(value)) begin
            res++;
        end
        return res;
    endfunction

    // Zero has no meaning as a tap, so it maps to the shortest delay.
    function automatic int unsigned clamp_delay(input int unsigned delay,
                                                input int unsigned max_delay);
        if (delay == 0) begin
            return 1;
        end
        if (delay > max_delay) begin
            return max_delay;
        end
        return delay;
    endfunction

endpackage

// File: rtl/prog_delay_line_if.sv
// ----------------------------------------------------------------------------
// prog_delay_line_if
// Stream + control bundle of the programmable delay line.
//   ce         : advance enable
//   din        : packed lane data, lane 0 in LSBs
//   din_valid  : qualifies din on ce cycles
//   delay      : requested delay (clamped inside the block)
//   dout       : delayed lane data (raw tap)
//   dout_valid : qualifies dout
//   primed     : history depth covers the active delay
// master drives the input side, slave is the delay line itself.
// ----------------------------------------------------------------------------
interface prog_delay_line_if import dsp_pkg::*; #(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned CHANNELS  = 1,
    parameter int unsigned MAX_DELAY = 16
);

    localparam int unsigned DW = clog2(MAX_DELAY + 1);

    logic                      ce;
    logic [CHANNELS*WIDTH-1:0] din;
    logic                      din_valid;
    logic [DW-1:0]             delay;
    logic [CHANNELS*WIDTH-1:0] dout;
    logic                      dout_valid;
    logic                      primed;

    modport master (
        output ce, din, din_valid, delay,
        input  dout, dout_valid, primed
    );

    modport slave (
        input  ce, din, din_valid, delay,
        output dout, dout_valid, primed
    );

endinterface

// File: rtl/delay_tap_lane.sv
// ----------------------------------------------------------------------------
// delay_tap_lane
// One data lane: MAX_DELAY-deep shift chain advancing on ce, read through a
// tap mux. tap_idx = k selects the sample shifted in k+1 ce-edges ago.
//   clk, rst : clock, synchronous active-high reset (clears all stages)
//   ce       : shift enable
//   din      : lane input word
//   tap_idx  : stage select (active delay - 1)
//   dout     : selected stage
// ----------------------------------------------------------------------------
module delay_tap_lane #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MAX_DELAY = 16,
    parameter int unsigned IW        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] din,
    input  logic [IW-1:0]    tap_idx,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [MAX_DELAY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MAX_DELAY; k++) begin
                stage_q[k] <= '0;
            end
        end else if (ce) begin
            stage_q[0] <= din;
            for (int k = 1; k < MAX_DELAY; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign dout = stage_q[tap_idx];

endmodule

// File: rtl/prog_delay_line.sv
// ----------------------------------------------------------------------------
// prog_delay_line
// Run-time programmable pipeline delay for CHANNELS parallel lanes sharing a
// valid sideband, clock enable and delay setting.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : prog_delay_line_if.slave (ce, din, din_valid, delay in;
//         dout, dout_valid, primed out)
// Holds the shared valid chain, active delay, fill counter and change detect;
// the data chains live in one delay_tap_lane per channel.
// ----------------------------------------------------------------------------
module prog_delay_line import dsp_pkg::*; #(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned CHANNELS  = 1,
    parameter int unsigned MAX_DELAY = 16
) (
    input logic              clk,
    input logic              rst,
    prog_delay_line_if.slave bus
);

    localparam int unsigned DW = clog2(MAX_DELAY + 1);
    localparam int unsigned IW = clog2(MAX_DELAY);

    logic [DW-1:0]             delay_req;
    logic [DW-1:0]             cur_delay_q, cur_delay_d;
    logic [DW-1:0]             fill_q, fill_d;
    logic [MAX_DELAY-1:0]      valid_q, valid_d;
    logic [IW-1:0]             tap_idx;
    logic                      delay_change;
    logic                      primed;
    logic [CHANNELS*WIDTH-1:0] dout_all;

    assign delay_req    = DW'(clamp_delay(32'(bus.delay), MAX_DELAY));
    assign delay_change = (delay_req != cur_delay_q);
    assign tap_idx      = IW'(cur_delay_q - DW'(1));

    always_comb begin
        cur_delay_d = cur_delay_q;
        fill_d      = fill_q;
        valid_d     = valid_q;
        if (bus.ce) begin
            valid_d = {valid_q[MAX_DELAY-2:0], bus.din_valid};
        end
        // Any change of the active tap restarts blanking; stage contents are kept.
        if (delay_change) begin
            cur_delay_d = delay_req;
            fill_d      = bus.ce ? DW'(1) : '0;
        end else if (bus.ce && (fill_q < DW'(MAX_DELAY))) begin
            fill_d = fill_q + DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_delay_q <= delay_req;
            fill_q      <= '0;
            valid_q     <= '0;
        end else begin
            cur_delay_q <= cur_delay_d;
            fill_q      <= fill_d;
            valid_q     <= valid_d;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        delay_tap_lane #(
            .WIDTH     (WIDTH),
            .MAX_DELAY (MAX_DELAY),
            .IW        (IW)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .ce      (bus.ce),
            .din     (bus.din[c*WIDTH +: WIDTH]),
            .tap_idx (tap_idx),
            .dout    (dout_all[c*WIDTH +: WIDTH])
        );
    end

    assign primed         = (fill_q >= cur_delay_q);
    assign bus.primed     = primed;
    assign bus.dout_valid = primed & valid_q[tap_idx];
    assign bus.dout       = dout_all;

endmodule

// File: tb/tb_prog_delay_line.sv
// ----------------------------------------------------------------------------
// tb_prog_delay_line
// Self-checking bench for prog_delay_line (WIDTH=16, CHANNELS=4, MAX_DELAY=16):
// a constant vector table, hand-written delay-change / clamp sequences, and a
// randomized run, all shadowed by a queue-based reference model.
// ----------------------------------------------------------------------------
module tb_prog_delay_line;

    localparam int unsigned WIDTH     = 16;
    localparam int unsigned CHANNELS  = 4;
    localparam int unsigned MAX_DELAY = 16;
    localparam int unsigned DATA_W    = CHANNELS * WIDTH;
    localparam int unsigned DW        = $clog2(MAX_DELAY + 1);

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              v;
    } sample_t;

    typedef struct {
        logic        rst;
        logic        ce;
        logic        dv;
        int unsigned delay;
        int unsigned din;
        int unsigned exp_dout;
        logic        exp_valid;
        logic        exp_primed;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: newest accepted sample at the front of the history.
    sample_t     hist[$];
    int unsigned m_cur  = 1;
    int unsigned m_fill = 0;

    int unsigned edges = 0;
    int unsigned seq_n = 0;
    int unsigned sent[0:4095];

    vec_t vecs[18];

    always #5 clk = ~clk;

    prog_delay_line_if #(
        .WIDTH     (WIDTH),
        .CHANNELS  (CHANNELS),
        .MAX_DELAY (MAX_DELAY)
    ) bus ();

    prog_delay_line #(
        .WIDTH     (WIDTH),
        .CHANNELS  (CHANNELS),
        .MAX_DELAY (MAX_DELAY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic int unsigned ref_clamp(input int unsigned d);
        if (d < 1) return 1;
        if (d > MAX_DELAY) return MAX_DELAY;
        return d;
    endfunction

    // Lane k carries 0x100*k + (n mod 256).
    function automatic logic [DATA_W-1:0] lanes(input int unsigned n);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            r[k*WIDTH +: WIDTH] = WIDTH'(32'h100 * k + (n % 256));
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic c, input logic v,
                              input int unsigned d, input logic [DATA_W-1:0] data);
        sample_t s;
        int unsigned cl;
        cl = ref_clamp(d);
        if (r) begin
            for (int i = 0; i < MAX_DELAY; i++) begin
                hist[i].data = '0;
                hist[i].v    = 1'b0;
            end
            m_fill = 0;
            m_cur  = cl;
        end else begin
            if (c) begin
                s.data = data;
                s.v    = v;
                hist.push_front(s);
                void'(hist.pop_back());
            end
            if (cl != m_cur) begin
                m_cur  = cl;
                m_fill = c ? 1 : 0;
            end else if (c && m_fill < MAX_DELAY) begin
                m_fill++;
            end
        end
    endtask

    // One clock: drive, let the edge happen, advance the model, compare 1ns later.
    task automatic step(input logic r, input logic c, input logic v,
                        input int unsigned d, input logic [DATA_W-1:0] data);
        logic mp;
        rst           = r;
        bus.ce        = c;
        bus.din_valid = v;
        bus.delay     = DW'(d);
        bus.din       = data;
        @(posedge clk);
        model_edge(r, c, v, d, data);
        if (c && !r) begin
            sent[edges % 4096] = data[WIDTH-1:0];
            edges++;
        end
        #1;
        mp = (m_fill >= m_cur);
        check("model_dout", bus.dout, hist[m_cur-1].data);
        check("model_valid", DATA_W'(bus.dout_valid), DATA_W'(mp && hist[m_cur-1].v));
        check("model_primed", DATA_W'(bus.primed), DATA_W'(mp));
    endtask

    // Switch to delay d with ce=1 and valid ramp data; count edges until dout_valid.
    task automatic run_count(input int unsigned d, input int unsigned bound,
                             output int unsigned cnt);
        cnt = 0;
        do begin
            step(1'b0, 1'b1, 1'b1, d, lanes(seq_n));
            seq_n++;
            cnt++;
        end while (!bus.dout_valid && cnt < bound);
    endtask

    initial begin
        int unsigned cnt;
        logic        r, c, v;
        int unsigned d;
        logic [DATA_W-1:0] data;

        for (int i = 0; i < MAX_DELAY; i++) begin
            sample_t z;
            z.data = '0;
            z.v    = 1'b0;
            hist.push_back(z);
        end
        rst           = 1'b1;
        bus.ce        = 1'b0;
        bus.din_valid = 1'b0;
        bus.delay     = DW'(2);
        bus.din       = '0;

        //             rst   ce    dv    dly din exp  valid primed
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 2,  0,  0,  1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 2,  1,  0,  1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 2,  2,  1,  1'b1, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 2,  3,  2,  1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 2,  4,  3,  1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 2,  99, 3,  1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 2,  98, 3,  1'b1, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 2,  5,  4,  1'b1, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 2,  6,  5,  1'b1, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 0,  7,  7,  1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 0,  8,  8,  1'b1, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 20, 9,  0,  1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 2,  10, 9,  1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 2,  11, 10, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 2,  12, 11, 1'b1, 1'b1};
        vecs[15] = '{1'b1, 1'b1, 1'b1, 2,  13, 0,  1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 2,  14, 0,  1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 1'b1, 2,  15, 14, 1'b1, 1'b1};

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].rst, vecs[i].ce, vecs[i].dv, vecs[i].delay, lanes(vecs[i].din));
            check($sformatf("vec%0d_dout", i), DATA_W'(bus.dout[WIDTH-1:0]),
                  DATA_W'(vecs[i].exp_dout));
            check($sformatf("vec%0d_lane3", i), DATA_W'(bus.dout[3*WIDTH +: WIDTH]),
                  DATA_W'(vecs[i].exp_dout == 0 ? 0 : 32'h300 + vecs[i].exp_dout));
            check($sformatf("vec%0d_valid", i), DATA_W'(bus.dout_valid),
                  DATA_W'(vecs[i].exp_valid));
            check($sformatf("vec%0d_primed", i), DATA_W'(bus.primed),
                  DATA_W'(vecs[i].exp_primed));
        end

        // Settle at delay 3, then 3 -> 7: seven edges of blanking including the switch.
        seq_n = 20;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b1, 3, lanes(seq_n));
            seq_n++;
        end
        run_count(7, 40, cnt);
        check("dly3to7_edges", DATA_W'(cnt), DATA_W'(7));
        check("dly3to7_data", DATA_W'(bus.dout[WIDTH-1:0]),
              DATA_W'(sent[(edges - 7) % 4096]));

        run_count(1, 40, cnt);
        check("dly7to1_edges", DATA_W'(cnt), DATA_W'(1));
        check("dly7to1_data", DATA_W'(bus.dout[WIDTH-1:0]),
              DATA_W'(sent[(edges - 1) % 4096]));

        run_count(MAX_DELAY + 3, 60, cnt);
        check("clamp_max_edges", DATA_W'(cnt), DATA_W'(MAX_DELAY));
        check("clamp_max_primed", DATA_W'(bus.primed), DATA_W'(1));

        run_count(0, 40, cnt);
        check("clamp_zero_edges", DATA_W'(cnt), DATA_W'(1));

        // Randomized traffic with occasional delay changes, stalls and resets.
        d = 4;
        for (int i = 0; i < 800; i++) begin
            r = ($urandom_range(0, 99) == 0);
            c = ($urandom_range(0, 3) != 0);
            v = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) begin
                d = $urandom_range(0, MAX_DELAY + 4);
            end
            data = {$urandom, $urandom};
            step(r, c, v, d, data);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d",
                 n_tests, n_fail);
        $fatal(1);
    end

endmodule
